// File: rtl/mod_intc.sv
// Memory-mapped interrupt controller: NSRC edge/level sources, w1c status, priority vector, int/int_ack handshake.
// Optional feature: define INTC_SYNC_EN to add a 2-flop negedge synchroniser on every irq line.
module mod_intc #(
    parameter int NSRC = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ie_i,
    input  logic            de_i,
    input  logic [31:0]     iaddr_i,
    input  logic [31:0]     daddr_i,
    input  logic [1:0]      drw_i,
    input  logic [31:0]     din_i,
    output logic [31:0]     iout_o,
    output logic [31:0]     dout_o,
    output logic            int_o,
    input  logic            int_ack_i,
    input  logic [NSRC-1:0] irq_i,
    output logic            dbg_state_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INT  = 1'b1
    } state_e;

    localparam logic [31:0] ADDR_MASK   = 32'h0;
    localparam logic [31:0] ADDR_STATUS = 32'h4;
    localparam logic [31:0] ADDR_MODE   = 32'h8;
    localparam logic [31:0] ADDR_VECTOR = 32'hC;

    state_e          state_q, state_d;
    logic [NSRC:0]   mask_q, mask_d;
    logic [NSRC:1]   status_q, status_d;
    logic [NSRC:1]   mode_q, mode_d;
    logic [NSRC-1:0] prev_q, prev_d;

    logic [NSRC-1:0] smp;
    logic [NSRC:1]   set_v;
    logic [NSRC:1]   clr_v;
    logic [NSRC:1]   pend;
    logic [31:0]     vector;
    logic            wr_en;
    logic            unused_ok;

    // Bus side that this block never uses; kept so the slave matches the CPU bus shape.
    assign unused_ok = ^{ie_i, iaddr_i, drw_i[1], din_i};

`ifdef INTC_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    always_ff @(negedge clk_i) begin
        if (!rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign smp = sync2_q;
`else
    assign smp = irq_i;
`endif

    assign wr_en = de_i & drw_i[0];
    assign pend  = mask_q[NSRC:1] & status_q;

    // Edge sources fire on a 0->1 of the sample; level sources fire every cycle the sample is high.
    assign set_v = (mode_q & smp & ~prev_q) | (~mode_q & smp);

    always_comb begin
        mask_d   = mask_q;
        mode_d   = mode_q;
        clr_v    = '0;
        prev_d   = smp;
        if (wr_en && (daddr_i == ADDR_MASK)) begin
            mask_d = din_i[NSRC:0];
        end
        // GIE stays off for the whole INT state; software must re-arm it after the ack.
        if (state_q == ST_INT) begin
            mask_d[0] = 1'b0;
        end
        if (wr_en && (daddr_i == ADDR_MODE)) begin
            mode_d = din_i[NSRC:1];
        end
        if (wr_en && (daddr_i == ADDR_STATUS)) begin
            clr_v = din_i[NSRC:1];
        end
        // Set is OR'ed after the clear so a same-cycle capture wins.
        status_d = (status_q & ~clr_v) | set_v;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mask_q[0] && (|pend)) state_d = ST_INT;
            ST_INT:  if (int_ack_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            status_q <= '0;
            mode_q   <= '0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            status_q <= status_d;
            mode_q   <= mode_d;
            prev_q   <= prev_d;
        end
    end

    // Lowest-numbered enabled pending source wins, so scan downwards and keep the last hit.
    always_comb begin
        vector = 32'h0;
        for (int k = NSRC; k >= 1; k--) begin
            if (pend[k]) vector = 32'(k);
        end
    end

    always_comb begin
        dout_o = 32'h0;
        case (daddr_i)
            ADDR_MASK:   dout_o = 32'(mask_q);
            ADDR_STATUS: dout_o = 32'({status_q, 1'b1});
            ADDR_MODE:   dout_o = 32'({mode_q, 1'b0});
            ADDR_VECTOR: dout_o = vector;
            default:     dout_o = 32'h0;
        endcase
    end

    assign iout_o      = 32'h0;
    assign int_o       = (state_q == ST_INT);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mod_intc.sv
// Bench for mod_intc (NSRC=4): registers commit on negedge; stimulus is driven and outputs are
// sampled 1 time unit after each negedge. Expected values go through exp_q before each comparison.
module tb_mod_intc;

  localparam int NSRC = 4;
`ifdef INTC_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic            clk;
  logic            rst;
  logic            ie;
  logic            de;
  logic [31:0]     iaddr;
  logic [31:0]     daddr;
  logic [1:0]      drw;
  logic [31:0]     din;
  logic [31:0]     iout;
  logic [31:0]     dout;
  logic            int_o;
  logic            int_ack;
  logic [NSRC-1:0] irq;
  logic            dbg_state;

  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] e;
  int n_cmp = 0;
  int n_bad = 0;

  mod_intc #(.NSRC(NSRC)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ie_i       (ie),
    .de_i       (de),
    .iaddr_i    (iaddr),
    .daddr_i    (daddr),
    .drw_i      (drw),
    .din_i      (din),
    .iout_o     (iout),
    .dout_o     (dout),
    .int_o      (int_o),
    .int_ack_i  (int_ack),
    .irq_i      (irq),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b1;
  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    de = 1'b1; drw = 2'b01; daddr = a; din = d;
    cyc();
    de = 1'b0; drw = 2'b00; din = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    daddr = a;
    #1;
    d = dout;
  endtask

  task automatic test_reset();
    rst = 1'b0; irq = '1; de = 1'b0; drw = 2'b00; int_ack = 1'b0;
    daddr = 32'h0; din = 32'h0; ie = 1'b0; iaddr = 32'h0;
    repeat (2) cyc();
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(32'(i * 4), got);
      e = exp_q.pop_front();
      if (got !== e) begin $display("FAIL reset_reg@%h: got %h want %h", i * 4, got, e); n_bad++; end
      n_cmp++;
    end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL reset_int: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front();
    if (iout !== e) begin $display("FAIL reset_iout: got %h want %h", iout, e); n_bad++; end
    n_cmp++;
    irq = '0;
    rst = 1'b1;
    repeat (L + 2) cyc();
  endtask

  task automatic test_decode();
    wr(32'h10, 32'hFFFF_FFFF);
    de = 1'b1; drw = 2'b10; daddr = 32'h0; din = 32'h1F;
    cyc();
    de = 1'b0; drw = 2'b00; din = 32'h0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    rd(32'h10, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL unmapped_rd: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    rd(32'h0, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL no_strobe_mask: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL decode_status: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    wr(32'h8, 32'hFFFF_FFFF);
    exp_q.push_back(32'h1E);
    rd(32'h8, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL mode_bits: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    wr(32'h8, 32'h0);
  endtask

  task automatic test_edge();
    wr(32'h8, 32'h4);
    wr(32'h0, 32'h5);
    irq = 4'b0010;
    cyc();
    irq = '0;
    repeat (L) cyc();
    exp_q.push_back(32'h5); exp_q.push_back(32'h2); exp_q.push_back(32'h0);
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL edge_status: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    rd(32'hC, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL edge_vector: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL edge_int_early: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    cyc();
    exp_q.push_back(32'h1);
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL edge_int: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL edge_ack_int: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    rd(32'h0, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL edge_ack_mask: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    cyc();
    exp_q.push_back(32'h0);
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL edge_no_rereq: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    wr(32'h4, 32'h4);
    exp_q.push_back(32'h1);
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL edge_w1c: got %h want %h", got, e); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_level_priority();
    wr(32'h8, 32'h0);
    wr(32'h0, 32'h1F);
    irq = 4'b1001;
    repeat (L + 1) cyc();
    exp_q.push_back(32'h1); exp_q.push_back(32'h13);
    rd(32'hC, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL lvl_vector1: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL lvl_status: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    wr(32'h4, 32'h2);
    exp_q.push_back(32'h13); exp_q.push_back(32'h1);
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL lvl_held_clear: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL lvl_int: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    irq = 4'b1000;
    repeat (L) cyc();
    wr(32'h4, 32'h2);
    exp_q.push_back(32'h4); exp_q.push_back(32'h11);
    rd(32'hC, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL lvl_vector4: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL lvl_status2: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    irq = '0;
    repeat (L + 1) cyc();
    wr(32'h4, 32'h1E);
    wr(32'h0, 32'h0);
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL lvl_cleanup: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL lvl_ack_int: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_race();
    wr(32'h8, 32'h8);
    irq = 4'b0100;
    repeat (L) cyc();
    wr(32'h4, 32'h8);
    exp_q.push_back(32'h9);
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL race_set_wins: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    wr(32'h4, 32'h8);
    exp_q.push_back(32'h1);
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL race_edge_held_clear: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    irq = '0;
    repeat (L + 1) cyc();
    wr(32'h8, 32'h0);
  endtask

  task automatic test_gie_lockout();
    wr(32'h0, 32'h3);
    irq = 4'b0001;
    repeat (L + 1) cyc();
    irq = '0;
    cyc();
    exp_q.push_back(32'h1);
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL gie_int: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    wr(32'h0, 32'hF);
    exp_q.push_back(32'hE);
    rd(32'h0, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL gie_mask_in_int: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    repeat (3) cyc();
    exp_q.push_back(32'h0); exp_q.push_back(32'h3);
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL gie_locked: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL gie_pending: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    wr(32'h0, 32'hF);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL gie_rearm_edge: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    cyc();
    exp_q.push_back(32'h1);
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL gie_rearm_int: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    wr(32'h4, 32'h2);
    wr(32'h0, 32'h0);
    exp_q.push_back(32'h1);
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL gie_cleanup: got %h want %h", got, e); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_latency();
    wr(32'h0, 32'h3);
    irq = 4'b0001;
    for (int k = 1; k <= L + 2; k++) begin
      cyc();
      exp_q.push_back((k >= L + 1) ? 32'h3 : 32'h1);
      exp_q.push_back((k >= L + 2) ? 32'h1 : 32'h0);
      rd(32'h4, got);
      e = exp_q.pop_front();
      if (got !== e) begin $display("FAIL lat_status k=%0d: got %h want %h", k, got, e); n_bad++; end
      n_cmp++;
      e = exp_q.pop_front();
      if (32'(int_o) !== e) begin $display("FAIL lat_int k=%0d: got %h want %h", k, int_o, e); n_bad++; end
      n_cmp++;
    end
    irq = '0;
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    repeat (L + 1) cyc();
    wr(32'h4, 32'h2);
    wr(32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_int();
    wr(32'h0, 32'h3);
    irq = 4'b0001;
    repeat (L + 2) cyc();
    irq = '0;
    rst = 1'b0;
    cyc();
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    e = exp_q.pop_front();
    if (32'(int_o) !== e) begin $display("FAIL rst_mid_int: got %h want %h", int_o, e); n_bad++; end
    n_cmp++;
    rd(32'h4, got);
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL rst_mid_status: got %h want %h", got, e); n_bad++; end
    n_cmp++;
    rst = 1'b1;
    repeat (L + 2) cyc();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_edge();
    test_level_priority();
    test_race();
    test_gie_lockout();
    test_latency();
    test_reset_mid_int();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
      n_bad++;
    end
    n_cmp++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_intc.md
# mod_intc

Parametrised interrupt controller, successor to the single-timer controller. It is generalised to `NSRC` external sources, each with a per-source edge/level mode. Status is write-one-to-clear, and a read-only vector register returns the highest-priority pending source. It sits on the CPU data bus as a memory-mapped slave and drives the CPU `int`/`int_ack` handshake.

## Interface
- `NSRC`, default 2, number of external sources, legal range 1..31; source k maps to status/mask bit k+1.
- `clk`  in  1  system clock; all register updates on negedge.
- `rst`  in  1  reset, synchronous, active-low.
- `ie`  in  1  instruction-bus enable, unused.
- `de`  in  1  data-bus enable.
- `iaddr`  in  32  instruction address, unused.
- `daddr`  in  32  data address; block-relative offset.
- `drw`  in  2  bit0 = write strobe.
- `din`  in  32  write data.
- `iout`  out  32  constant 0; never executable.
- `dout`  out  32  combinational read data.
- `int`  out  1  interrupt request to CPU.
- `int_ack`  in  1  CPU acknowledge.
- `irq`  in  NSRC  raw external interrupt lines.

## Operation
- Register map (offsets decoded by full compare; any other offset reads 0 and ignores writes):
  - 0x0 MASK (rw): bit0 = GIE; bits 1..NSRC = per-source enable; upper bits read 0.
  - 0x4 STATUS (w1c): bit0 reads 1 always; bits 1..NSRC = pending; writing 1 clears a bit; writing 0 has no effect.
  - 0x8 MODE (rw): bit k+1 = 1 edge (rising), 0 level; bit0 and upper bits read 0.
  - 0xC VECTOR (ro): index (1..NSRC) of the lowest-numbered bit set in MASK&STATUS[NSRC:1]; 0 when none. Lowest index = highest priority.
- Writes take effect only when `de && drw[0]`.
- Source capture, per cycle, for sample s_k (see Configuration):
  - Edge mode: set STATUS[k+1] when s_k=1 and prev_k=0.
  - Level mode: set STATUS[k+1] whenever s_k=1.
- Set has priority over a same-cycle w1c clear. A level source therefore cannot be cleared while its line is high.
- FSM, 2 states:
  - IDLE -> INT when GIE=1 and (MASK[NSRC:1] & STATUS[NSRC:1]) != 0.
  - INT -> IDLE when `int_ack`=1.
  - `int` = (state==INT).
- While in INT, GIE is forced to 0 every cycle and software writes to MASK bit0 are ignored; other MASK bits are writable. After return to IDLE, no new request is issued until software sets GIE.
- Reset (rst=0 at negedge): MASK=0, STATUS[NSRC:1]=0, MODE=0, edge history=0, synchroniser=0, state=IDLE. Outputs during reset: `int`=0, `iout`=0, `dout` per decoded (reset) registers.

## Timing
- `dout` combinational from `daddr` and current registers, zero wait.
- Raw `irq` edge to STATUS set: 1 negedge (2 more with sync). Status set to `int` high: 1 further negedge.
- `int_ack` sampled at negedge while in INT; `int` drops the same edge.
- `int_ack` in IDLE is ignored.
- Write to STATUS/MASK is visible on `dout` after the negedge that commits it.
- Reset mid-INT: `int` falls at the reset edge; pending history is lost.

## Configuration
- `INTC_SYNC_EN` defined: each `irq` bit passes through a 2-flop negedge synchroniser; s_k is the second flop. Capture latency is +2 cycles. Synchroniser flops reset to 0.
- Not defined: s_k = `irq[k]` directly; the block requires synchronous sources.

## Test plan
- Reset: hold rst=0 for 2 negedges with `irq`=all-1 -> `int`=0, read 0x0=0, 0x4=0x1, 0x8=0, 0xC=0.
- Edge source: NSRC=4, MODE=0x4, MASK=0x5, pulse irq[1] for 1 cycle -> STATUS=0x5, VECTOR=2, `int`=1 the next negedge; ack -> `int`=0, MASK reads 0x4.
- Level priority: MODE=0, MASK=0x1F, irq[3] and irq[0] high -> VECTOR=1; w1c 0x2 with irq[0] still high -> STATUS bit1 stays set; drop irq[0], w1c 0x2 -> VECTOR=4.
- Set-vs-clear race: edge on irq[2] in the same cycle as w1c 0x8 -> STATUS bit3 remains 1.
- GIE lockout: in INT, write MASK=0xF -> reads 0xE; after ack, `int` stays 0 until MASK bit0 is written 1.
- Sync latency (`INTC_SYNC_EN`): irq[0] rise -> STATUS bit1 set 3 negedges later, `int` 4 negedges later; without the macro, 1 and 2.
